// File: rtl/if_stage_pkg.sv
// Shared rv32i fetch-stage types: machine word, opcodes, IF FSM states and the IF/ID slot record.
// The B-type immediate helper exists only when IF_BTFN_PREDICT_EN is defined.
package if_stage_pkg;

   typedef logic [31:0] rv32i_word;

   typedef enum logic [6:0] {
      op_lui   = 7'b0110111,
      op_auipc = 7'b0010111,
      op_jal   = 7'b1101111,
      op_jalr  = 7'b1100111,
      op_br    = 7'b1100011,
      op_load  = 7'b0000011,
      op_store = 7'b0100011,
      op_imm   = 7'b0010011,
      op_reg   = 7'b0110011,
      op_csr   = 7'b1110011
   } rv32i_opcode;

   // FETCH: read outstanding; HOLD: fetched word parked in skid; DRAIN: discard one stale response.
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } if_state_t;

   typedef struct packed {
      rv32i_word pc;
      rv32i_word instruction;
      logic      valid;
      logic      pred_taken;
   } if_id_t;

   localparam rv32i_word IF_RESET_PC = 32'h0000_0060;

   function automatic rv32i_word word_align(input rv32i_word addr);
      return addr & ~32'h0000_0003;
   endfunction

`ifdef IF_BTFN_PREDICT_EN
   function automatic rv32i_word b_imm(input rv32i_word instr);
      return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
   endfunction
`endif

endpackage

// File: rtl/if_stage_pc_reg.sv
// Fetch program counter: 32-bit register with load enable, async active-low reset to RESET_PC.
module pc_reg
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] d,
   output logic [31:0] pc
);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc <= RESET_PC;
      end else if (load) begin
         pc <= d;
      end
   end

endmodule

// File: rtl/if_stage.sv
// rv32i instruction-fetch stage: owns the PC, drives imem reads and the registered IF/ID slot.
// Optional backward-taken branch prediction is enabled by defining IF_BTFN_PREDICT_EN.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_read,
   output logic [31:0] imem_address,
   input  logic [31:0] imem_rdata,
   input  logic        imem_resp,
   input  logic        stall_in,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instruction,
   output logic        if_pred_taken
);

   if_state_t state;
   if_state_t state_next;
   rv32i_word pc;
   rv32i_word pc_next;
   rv32i_word seq_pc;
   rv32i_word drain_addr;
   logic      pc_load;
   logic      pred;
   logic      slot_free;
   if_id_t    slot;
   if_id_t    slot_next;
   if_id_t    skid;
   if_id_t    skid_next;
   if_id_t    fetched;

   pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk  (clk),
      .rst  (rst),
      .load (pc_load),
      .d    (pc_next),
      .pc   (pc)
   );

`ifdef IF_BTFN_PREDICT_EN
   // Backward conditional branches are predicted taken; EX redirects on a mispredict.
   assign pred   = (imem_rdata[6:0] == op_br) && imem_rdata[31];
   assign seq_pc = pred ? pc + b_imm(imem_rdata) : pc + 32'd4;
`else
   assign pred   = 1'b0;
   assign seq_pc = pc + 32'd4;
`endif

   assign slot_free = !slot.valid || !stall_in;
   assign fetched   = '{pc: pc, instruction: imem_rdata, valid: 1'b1, pred_taken: pred};

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      pc_load    = 1'b0;
      pc_next    = seq_pc;
      slot_next  = slot;
      skid_next  = skid;

      case (state)
         FETCH: begin
            if (imem_resp) begin
               pc_load = 1'b1;
               if (slot_free) begin
                  slot_next = fetched;
               end else begin
                  skid_next  = fetched;
                  state_next = HOLD;
               end
            end else if (slot_free) begin
               slot_next.valid = 1'b0;
            end
         end
         HOLD: begin
            if (!stall_in) begin
               slot_next       = skid;
               skid_next.valid = 1'b0;
               state_next      = FETCH;
            end
         end
         DRAIN: begin
            if (slot_free) begin
               slot_next.valid = 1'b0;
            end
            if (imem_resp) begin
               state_next = FETCH;
            end
         end
         default: begin
            state_next = FETCH;
         end
      endcase

      // A redirect overrides everything; a read still in flight must finish on its old address.
      if (redirect) begin
         slot_next.valid = 1'b0;
         skid_next.valid = 1'b0;
         pc_load         = 1'b1;
         pc_next         = word_align(redirect_pc);
         state_next      = ((state != HOLD) && !imem_resp) ? DRAIN : FETCH;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= FETCH;
         slot       <= '0;
         skid       <= '0;
         drain_addr <= '0;
      end else begin
         state <= state_next;
         slot  <= slot_next;
         skid  <= skid_next;
         if (redirect && (state == FETCH) && !imem_resp) begin
            drain_addr <= word_align(pc);
         end
      end
   end

   assign imem_read      = rst && (state != HOLD);
   assign imem_address   = (state == DRAIN) ? drain_addr : word_align(pc);
   assign if_valid       = slot.valid;
   assign if_pc          = slot.pc;
   assign if_instruction = slot.instruction;
   assign if_pred_taken  = slot.pred_taken;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a scoreboarded memory model plus an ID-side slot consumer.
// Define IF_BTFN_PREDICT_EN for both bench and RTL to exercise the predictor expectations.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_read;
   logic [31:0] imem_address;
   logic [31:0] imem_rdata = '0;
   logic        imem_resp = 1'b0;
   logic        stall_in = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instruction;
   logic        if_pred_taken;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        pred;
   } slot_exp_t;

   slot_exp_t   exp_slot[$];
   logic [31:0] exp_req[$];
   logic [31:0] ovr[logic [31:0]];
   int          mem_lat = 1;
   int          mem_cnt = 0;
   bit          mem_busy = 1'b0;
   logic [31:0] cur_addr = '0;
   int          n_checks = 0;
   int          n_pass = 0;

   if_stage dut (
      .clk            (clk),
      .rst            (rst),
      .imem_read      (imem_read),
      .imem_address   (imem_address),
      .imem_rdata     (imem_rdata),
      .imem_resp      (imem_resp),
      .stall_in       (stall_in),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_instruction (if_instruction),
      .if_pred_taken  (if_pred_taken)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      if (ovr.exists(addr)) return ovr[addr];
      return {addr[26:2], 7'h13};
   endfunction

   task automatic expect_slot(input logic [31:0] pc, input logic [31:0] instr, input logic pred);
      slot_exp_t e;
      e.pc    = pc;
      e.instr = instr;
      e.pred  = pred;
      exp_slot.push_back(e);
   endtask

   // Memory: serves only requests the test has queued, responds mem_lat negedges after seeing them.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            mem_busy  = 1'b0;
            imem_resp = 1'b0;
         end else begin
            if (imem_resp) begin
               imem_resp = 1'b0;
               mem_busy  = 1'b0;
            end else if (mem_busy) begin
               check("addr_hold", imem_address, cur_addr);
               check("read_hold", imem_read, 1);
               mem_cnt--;
            end
            if (!mem_busy && imem_read && exp_req.size() > 0) begin
               check("req_addr", imem_address, exp_req.pop_front());
               cur_addr = imem_address;
               mem_busy = 1'b1;
               mem_cnt  = mem_lat;
            end
            if (mem_busy && !imem_resp && mem_cnt <= 0) begin
               imem_resp  = 1'b1;
               imem_rdata = mem_word(cur_addr);
            end
         end
      end
   end

   // ID side: a live, unstalled, unflushed slot is consumed at the coming edge.
   initial begin
      slot_exp_t e;
      forever begin
         @(negedge clk);
         if (rst && if_valid && !stall_in && !redirect) begin
            if (exp_slot.size() == 0) begin
               check("slot_unexpected_pc", if_pc, 32'hFFFF_FFFF);
            end else begin
               e = exp_slot.pop_front();
               check("slot_pc", if_pc, e.pc);
               check("slot_instr", if_instruction, e.instr);
               check("slot_pred", if_pred_taken, e.pred);
            end
         end
      end
   end

   task automatic wait_idle(input string tag);
      bit done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(posedge clk);
         if (exp_req.size() == 0 && !mem_busy && exp_slot.size() == 0 && !if_valid) done = 1'b1;
      end
      check({tag, "_idle"}, done, 1);
      #1;
   endtask

   task automatic pulse_redirect(input logic [31:0] target);
      redirect    = 1'b1;
      redirect_pc = target;
      @(posedge clk);
      #1;
      redirect    = 1'b0;
   endtask

   initial begin
      bit seen;

      // Reset state
      #1;
      check("rst_valid", if_valid, 0);
      check("rst_read", imem_read, 0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_pc", if_pc, 0);
      check("rst_instr", if_instruction, 0);
      check("rst_pred", if_pred_taken, 0);
      check("rst_addr", imem_address, 32'h60);

      // 1: sequential fetch with no stall
      exp_req.push_back(32'h60);
      exp_req.push_back(32'h64);
      exp_req.push_back(32'h68);
      expect_slot(32'h60, mem_word(32'h60), 1'b0);
      expect_slot(32'h64, mem_word(32'h64), 1'b0);
      expect_slot(32'h68, mem_word(32'h68), 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("first_read", imem_read, 1);
      check("first_addr", imem_address, 32'h60);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk);
         seen = imem_resp;
      end
      #1;
      check("lat_seen", seen, 1);
      check("lat_valid", if_valid, 1);
      check("lat_pc", if_pc, 32'h60);
      wait_idle("seq");
      check("seq_next_addr", imem_address, 32'h6C);
      check("seq_next_read", imem_read, 1);

      // 2: stall with a live slot parks the next word in the skid
      stall_in = 1'b1;
      ovr[32'h70] = 32'h0000_0013;
      exp_req.push_back(32'h6C);
      exp_req.push_back(32'h70);
      expect_slot(32'h6C, mem_word(32'h6C), 1'b0);
      expect_slot(32'h70, 32'h0000_0013, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk);
         #1;
         seen = !imem_read;
      end
      check("hold_entered", seen, 1);
      repeat (3) @(posedge clk);
      #1;
      check("hold_read", imem_read, 0);
      check("hold_valid", if_valid, 1);
      check("hold_pc", if_pc, 32'h6C);
      check("hold_instr", if_instruction, mem_word(32'h6C));
      stall_in = 1'b0;
      wait_idle("hold");
      check("hold_resume_addr", imem_address, 32'h74);
      check("hold_resume_read", imem_read, 1);

      // 3: redirect while a slow read is pending, then a second redirect inside DRAIN
      mem_lat = 3;
      exp_req.push_back(32'h74);
      exp_req.push_back(32'h200);
      expect_slot(32'h200, mem_word(32'h200), 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk);
         seen = mem_busy;
      end
      check("drain_req_seen", seen, 1);
      #1;
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      @(posedge clk);
      #1;
      check("drain_addr_stale", imem_address, 32'h74);
      check("drain_read", imem_read, 1);
      check("drain_valid", if_valid, 0);
      redirect_pc = 32'h203;
      @(posedge clk);
      #1;
      redirect = 1'b0;
      mem_lat  = 1;
      check("drain_addr_stale2", imem_address, 32'h74);
      wait_idle("drain");
      check("drain_after_addr", imem_address, 32'h204);

      // 4: redirect on the same edge as a response: no DRAIN
      exp_req.push_back(32'h204);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         #1;
         seen = imem_resp;
      end
      check("same_resp_seen", seen, 1);
      pulse_redirect(32'h200);
      check("same_valid", if_valid, 0);
      check("same_read", imem_read, 1);
      check("same_addr", imem_address, 32'h200);
      exp_req.push_back(32'h200);
      expect_slot(32'h200, mem_word(32'h200), 1'b0);
      wait_idle("same");

      // 5: PC wraps from the top of the address space
      exp_req.push_back(32'h204);
      exp_req.push_back(32'hFFFF_FFFC);
      exp_req.push_back(32'h0);
      expect_slot(32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), 1'b0);
      expect_slot(32'h0, mem_word(32'h0), 1'b0);
      pulse_redirect(32'hFFFF_FFFC);
      wait_idle("wrap");
      check("wrap_addr", imem_address, 32'h4);

      // 6: backward and forward conditional branches
      ovr[32'h100] = 32'hFE00_0EE3;
      ovr[32'h300] = 32'h0000_0463;
      exp_req.push_back(32'h4);
      exp_req.push_back(32'h100);
`ifdef IF_BTFN_PREDICT_EN
      exp_req.push_back(32'hFC);
      expect_slot(32'h100, 32'hFE00_0EE3, 1'b1);
      expect_slot(32'hFC, mem_word(32'hFC), 1'b0);
`else
      exp_req.push_back(32'h104);
      expect_slot(32'h100, 32'hFE00_0EE3, 1'b0);
      expect_slot(32'h104, mem_word(32'h104), 1'b0);
`endif
      pulse_redirect(32'h100);
      wait_idle("br_back");
`ifdef IF_BTFN_PREDICT_EN
      check("br_back_addr", imem_address, 32'h100);
      exp_req.push_back(32'h100);
`else
      check("br_back_addr", imem_address, 32'h108);
      exp_req.push_back(32'h108);
`endif
      exp_req.push_back(32'h300);
      exp_req.push_back(32'h304);
      expect_slot(32'h300, 32'h0000_0463, 1'b0);
      expect_slot(32'h304, mem_word(32'h304), 1'b0);
      pulse_redirect(32'h300);
      wait_idle("br_fwd");
      check("br_fwd_addr", imem_address, 32'h308);

      // 7: asynchronous reset mid-cycle
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("arst_valid", if_valid, 0);
      check("arst_read", imem_read, 0);
      check("arst_pc", if_pc, 0);
      check("arst_addr", imem_address, 32'h60);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
